// File: rtl/control_sequencer.sv
// Microcoded control sequencer: decodes opcode + flags into a 16-bit control word and
// steps microsteps on tick. Optional feature macro: CONTROL_SEQUENCER_EARLY_END_EN.
module control_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int STEPS        = 5,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  step_req,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  flag_c,
    input  logic                  flag_z,
    output logic [15:0]           ctrl,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  halted,
    output logic                  instr_done
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_TWO  = STEP_WIDTH'(2);

    localparam logic [15:0] CW_FETCH0 = 16'h4004;
    localparam logic [15:0] CW_FETCH1 = 16'h1408;
    localparam logic [15:0] CW_IR_MAR = 16'h4800;
    localparam logic [15:0] CW_RAM_A  = 16'h1200;
    localparam logic [15:0] CW_RAM_B  = 16'h1020;
    localparam logic [15:0] CW_ADD    = 16'h0281;
    localparam logic [15:0] CW_SUB    = 16'h02C1;
    localparam logic [15:0] CW_STORE  = 16'h2100;
    localparam logic [15:0] CW_LDI    = 16'h0A00;
    localparam logic [15:0] CW_JUMP   = 16'h0802;
    localparam logic [15:0] CW_OUT    = 16'h0110;
    localparam logic [15:0] CW_HALT   = 16'h8000;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    opcode_legal;
    logic [3:0]              op_eff;
    logic [15:0]             word;
    logic [15:0]             ctrl_int;
    logic                    adv;
    logic                    hlt_hit;
    logic                    early_end;
    logic                    wrap;

    logic [STEP_WIDTH-1:0]   step_q, step_d;
    logic                    halted_q, halted_d;
    logic                    pending_q, pending_d;
    logic                    done_q, done_d;

    function automatic logic [15:0] microcode(
        input logic [STEP_WIDTH-1:0] s,
        input logic [3:0]            op,
        input logic                  c,
        input logic                  z
    );
        logic [15:0] w;
        w = 16'h0000;
        case (int'(s))
            0: w = CW_FETCH0;
            1: w = CW_FETCH1;
            2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: w = CW_IR_MAR;
                    4'h5: w = CW_LDI;
                    4'h6: w = CW_JUMP;
                    4'h7: w = c ? CW_JUMP : 16'h0000;
                    4'h8: w = z ? CW_JUMP : 16'h0000;
                    4'hE: w = CW_OUT;
                    4'hF: w = CW_HALT;
                    default: w = 16'h0000;
                endcase
            end
            3: begin
                case (op)
                    4'h1: w = CW_RAM_A;
                    4'h2, 4'h3: w = CW_RAM_B;
                    4'h4: w = CW_STORE;
                    default: w = 16'h0000;
                endcase
            end
            4: begin
                case (op)
                    4'h2: w = CW_ADD;
                    4'h3: w = CW_SUB;
                    default: w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    assign opcode = instr_in[DATA_WIDTH-1 -: OPCODE_WIDTH];

    // Wider opcodes only map onto the 4-bit table when their upper bits are clear.
    generate
        if (OPCODE_WIDTH > 4) begin : g_wide_opcode
            assign opcode_legal = (opcode[OPCODE_WIDTH-1:4] == '0);
        end else begin : g_narrow_opcode
            assign opcode_legal = 1'b1;
        end
        if (DATA_WIDTH > OPCODE_WIDTH) begin : g_operand
            logic unused_operand_bits;
            assign unused_operand_bits = ^instr_in[DATA_WIDTH-OPCODE_WIDTH-1:0];
        end
    endgenerate

    assign op_eff = opcode_legal ? opcode[3:0] : 4'h0;

    always_comb begin
        word      = microcode(step_q, op_eff, flag_c, flag_z);
        ctrl_int  = halted_q ? 16'h0000 : word;
        adv       = tick & ~halted_q & (run | pending_q);
        hlt_hit   = adv & ctrl_int[15];
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
        early_end = (step_q >= STEP_TWO) && (ctrl_int == 16'h0000);
`else
        early_end = 1'b0;
`endif
        wrap      = adv & ~hlt_hit & ((step_q == LAST_STEP) | early_end);

        step_d = step_q;
        if (adv && !hlt_hit) begin
            step_d = wrap ? '0 : step_q + STEP_WIDTH'(1);
        end
        halted_d  = halted_q | hlt_hit;
        // A request arriving with an advance survives, so it yields one further advance.
        pending_d = (pending_q & ~adv) | (step_req & ~run & ~halted_q);
        done_d    = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q    <= '0;
            halted_q  <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            step_q    <= step_d;
            halted_q  <= halted_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign ctrl       = ctrl_int;
    assign step       = step_q;
    assign halted     = halted_q;
    assign instr_done = done_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then random traffic, checked against
// a table-driven reference model with immediate assertions.
module tb_control_sequencer;

    localparam int DATA_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 4;
    localparam int STEPS        = 5;
    localparam int STEP_WIDTH   = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  tick = 1'b0;
    logic                  run = 1'b0;
    logic                  step_req = 1'b0;
    logic [DATA_WIDTH-1:0] instr_in = '0;
    logic                  flag_c = 1'b0;
    logic                  flag_z = 1'b0;
    logic [15:0]           ctrl;
    logic [STEP_WIDTH-1:0] step;
    logic                  halted;
    logic                  instr_done;

    control_sequencer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .STEPS       (STEPS),
        .STEP_WIDTH  (STEP_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run       (run),
        .step_req  (step_req),
        .instr_in  (instr_in),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (ctrl),
        .step      (step),
        .halted    (halted),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] tab [16][8];
    int          m_step;
    bit          m_halt, m_pend, m_done;

    function automatic logic [15:0] m_ctrl();
        int          op;
        logic [15:0] w;
        if (m_halt || m_step >= STEPS) return 16'h0000;
        op = int'(instr_in[DATA_WIDTH-1 -: OPCODE_WIDTH]);
        w  = tab[op][m_step];
        if (m_step == 2 && ((op == 7 && !flag_c) || (op == 8 && !flag_z))) w = 16'h0000;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_step"}, 32'(step), 32'(m_step));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(m_ctrl()));
        check({tag, "_halted"}, 32'(halted), 32'(m_halt));
        check({tag, "_done"}, 32'(instr_done), 32'(m_done));
    endtask

    // One clock: model predicts from pre-edge inputs, outputs compared after the edge.
    task automatic cycle(input bit t, input bit sr, input string tag);
        bit          adv, wrap;
        logic [15:0] w;
        int          n_step;
        bit          n_halt, n_pend;
        tick = t;
        step_req = sr;
        w = m_ctrl();
        if (rst) begin
            n_step = 0; n_halt = 0; n_pend = 0; wrap = 0;
        end else begin
            adv    = t && !m_halt && (run || m_pend);
            n_step = m_step;
            n_halt = m_halt;
            wrap   = 0;
            if (adv) begin
                if (w[15]) n_halt = 1;
                else begin
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
                    wrap = (m_step == STEPS - 1) || (m_step >= 2 && w == 16'h0000);
`else
                    wrap = (m_step == STEPS - 1);
`endif
                    n_step = wrap ? 0 : m_step + 1;
                end
            end
            n_pend = (m_pend && !adv) || (sr && !run && !m_halt);
        end
        @(posedge clk);
        #1;
        m_step = n_step; m_halt = n_halt; m_pend = n_pend; m_done = wrap;
        tick = 1'b0;
        step_req = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, "rst");
        rst = 1'b0;
    endtask

    logic [15:0] add_seq [5];

    initial begin
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 8; s++) tab[o][s] = 16'h0000;
        for (int o = 0; o < 16; o++) begin
            tab[o][0] = 16'h4004;
            tab[o][1] = 16'h1408;
        end
        tab[1][2] = 16'h4800; tab[1][3] = 16'h1200;
        tab[2][2] = 16'h4800; tab[2][3] = 16'h1020; tab[2][4] = 16'h0281;
        tab[3][2] = 16'h4800; tab[3][3] = 16'h1020; tab[3][4] = 16'h02C1;
        tab[4][2] = 16'h4800; tab[4][3] = 16'h2100;
        tab[5][2] = 16'h0A00;
        tab[6][2] = 16'h0802;
        tab[7][2] = 16'h0802;
        tab[8][2] = 16'h0802;
        tab[14][2] = 16'h0110;
        tab[15][2] = 16'h8000;
        m_step = 0; m_halt = 0; m_pend = 0; m_done = 0;
        add_seq = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};

        // Reset state
        do_reset();
        cycle(0, 0, "idle");
        check("t1_ctrl", 32'(ctrl), 32'h4004);

        // ADD in free-run
        run = 1'b1;
        instr_in = 8'h2A;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_ctrl%0d", i), 32'(ctrl), 32'(add_seq[i]));
            cycle(1, 0, "t2");
        end
        check("t2_done", 32'(instr_done), 32'h1);
        check("t2_wrap", 32'(step), 32'h0);
        cycle(0, 0, "t2_after");

        // JC decision follows flag_c combinationally
        do_reset();
        instr_in = 8'h70;
        flag_c = 1'b0;
        cycle(1, 0, "t3"); cycle(1, 0, "t3");
        #1; check("t3_jc_nc", 32'(ctrl), 32'h0000);
        flag_c = 1'b1;
        #1; check("t3_jc_c", 32'(ctrl), 32'h0802);

        // HLT latches and holds
        do_reset();
        instr_in = 8'hF0;
        cycle(1, 0, "t4"); cycle(1, 0, "t4");
        cycle(1, 0, "t4_hlt");
        check("t4_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) cycle(1, 1, "t4_hold");
        check("t4_step", 32'(step), 32'h2);
        do_reset();
        check("t4_unhalt", 32'(halted), 32'h0);

        // Single-step
        run = 1'b0;
        instr_in = 8'h20;
        cycle(0, 1, "t5_req");
        for (int i = 0; i < 3; i++) cycle(1, 0, "t5_tick");
        check("t5_once", 32'(step), 32'h1);
        cycle(0, 1, "t5_req2");
        cycle(1, 1, "t5_coinc");
        cycle(1, 0, "t5_more");
        check("t5_extra", 32'(step), 32'h3);

        // LDI leaving s3
        do_reset();
        run = 1'b1;
        instr_in = 8'h50;
        for (int i = 0; i < 3; i++) cycle(1, 0, "t6");
        cycle(1, 0, "t6_s3");
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
        check("t6_step", 32'(step), 32'h0);
        check("t6_done", 32'(instr_done), 32'h1);
`else
        check("t6_step", 32'(step), 32'h4);
        check("t6_done", 32'(instr_done), 32'h0);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) run = ~run;
            instr_in = DATA_WIDTH'($urandom);
            flag_c   = 1'($urandom);
            flag_z   = 1'($urandom);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), "rnd");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
